mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl_if.sv | 33 +++
 rtl/mac_seq_ctrl.sv | 97 +++++++++
 tb/tb_mac_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Bundles the job, operand, MAC and result signals of the dot-product sequencer.
// The slave modport is the controller's view. The master modport is the view of the job source and the MAC.
interface mac_seq_ctrl_if #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN_W     = 8
);
    logic                 start;
    logic [LEN_W-1:0]     len;
    logic [ACC_WIDTH-1:0] bias;
    logic                 op_valid;
    logic [IN_WIDTH-1:0]  op_a;
    logic [IN_WIDTH-1:0]  op_b;
    logic                 op_ready;
    logic                 mac_en;
    logic [IN_WIDTH-1:0]  mac_a;
    logic [IN_WIDTH-1:0]  mac_b;
    logic [ACC_WIDTH-1:0] mac_acc_in;
    logic [ACC_WIDTH-1:0] mac_acc_out;
    logic                 busy;
    logic [ACC_WIDTH-1:0] result;
    logic                 result_valid;

    modport slave (
        input  start, len, bias, op_valid, op_a, op_b, mac_acc_out,
        output op_ready, mac_en, mac_a, mac_b, mac_acc_in, busy, result, result_valid
    );

    modport master (
        output start, len, bias, op_valid, op_a, op_b, mac_acc_out,
        input  op_ready, mac_en, mac_a, mac_b, mac_acc_in, busy, result, result_valid
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences one dot product through an external pipelined MAC.
// Exactly one term is in flight at a time, and the running sum is kept in acc_q.
module mac_seq_ctrl #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN_W     = 8,
    parameter int MAC_LAT   = 2
) (
    input logic           clk,
    input logic           rst,
    mac_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int CNT_W = 3;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 op_ready, mac_en, result_valid;
    logic [IN_WIDTH-1:0]  op_a, op_b;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            wait_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wait_q   <= wait_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        wait_d       = wait_q;
        acc_d        = acc_q;
        result_d     = result_q;
        op_ready     = 1'b0;
        mac_en       = 1'b0;
        result_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.len;
                    acc_d   = bus.bias;
                    state_d = (bus.len != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                op_ready = 1'b1;
                mac_en   = bus.op_valid;
                if (bus.op_valid) begin
                    rem_d   = rem_q - LEN_W'(1);
                    wait_d  = CNT_W'(MAC_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q - CNT_W'(1);
                // The MAC_LAT-th edge after the issue edge samples the finished sum.
                if (wait_q == CNT_W'(1)) begin
                    acc_d   = bus.mac_acc_out;
                    state_d = (rem_q != '0) ? ISSUE : DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Loading result on entry to DONE keeps it registered and stable until the next DONE.
        if (state_d == DONE) result_d = acc_d;
    end

    assign op_a = bus.op_a;
    assign op_b = bus.op_b;

    assign bus.op_ready     = op_ready;
    assign bus.mac_en       = mac_en;
    assign bus.mac_a        = op_a;
    assign bus.mac_b        = op_b;
    assign bus.mac_acc_in   = acc_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural pipelined MAC.
// Expected results are queued at job start and checked by a separate monitor.
module tb_mac_seq_ctrl;
    localparam int IW  = 8;
    localparam int AW  = 16;
    localparam int LW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .LEN_W(LW)) bus ();

    mac_seq_ctrl #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .LEN_W(LW), .MAC_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The MAC model is deliberately not reset, so that a stale result can arrive after a controller reset.
    logic [AW-1:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        logic [AW-1:0] wa, wb;
        wa = AW'(bus.mac_a);
        wb = AW'(bus.mac_b);
        if (bus.mac_en) pipe[0] <= wa * wb + bus.mac_acc_in;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mac_acc_out = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int mac_en_cnt = 0;
    bit prev_rv = 1'b0;

    typedef struct {
        logic [AW-1:0] res;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop on result_valid, plus protocol checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mac_en) begin
                mac_en_cnt++;
                if (!bus.op_ready) begin
                    tests++;
                    fails++;
                    $display("FAIL mac_en_outside_issue at cycle %0d", cyc);
                end
            end
            if (bus.result_valid) begin
                if (prev_rv) begin
                    tests++;
                    fails++;
                    $display("FAIL result_valid_width: high two cycles running at cycle %0d", cyc);
                end
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result_valid: result %0d at cycle %0d", bus.result, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", 32'(bus.result), 32'(mon_e.res));
                    if (mon_e.cyc >= 0) check("result_latency_edge", cyc, mon_e.cyc);
                end
            end
        end
        prev_rv = bus.result_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [LW-1:0] l, input logic [AW-1:0] b,
                             input logic [AW-1:0] exp_res, input bit timed);
        exp_t e;
        bus.start = 1'b1;
        bus.len   = l;
        bus.bias  = b;
        tick();
        bus.start = 1'b0;
        bus.len   = 8'hA5;
        bus.bias  = 16'hBEEF;
        e.res = exp_res;
        e.cyc = timed ? cyc + int'(l) * (LAT + 1) : -1;
        sb_q.push_back(e);
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic send_pair(input logic [IW-1:0] a, input logic [IW-1:0] b, input int gap);
        bit ok;
        bus.op_valid = 1'b0;
        repeat (gap) tick();
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.op_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL op_ready_timeout: pair (%0d,%0d) never accepted", a, b);
        end
        tick();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("job_completes", 32'(ok), 32'd1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},         32'(bus.busy),         32'd0);
        check({tag, "_op_ready"},     32'(bus.op_ready),     32'd0);
        check({tag, "_mac_en"},       32'(bus.mac_en),       32'd0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_result"},       32'(bus.result),       32'd0);
        check({tag, "_mac_acc_in"},   32'(bus.mac_acc_in),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.bias     = '0;
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        // len=1, bias=10, (3,4) -> 22
        start_job(8'd1, 16'd10, 16'd22, 1'b1);
        send_pair(8'd3, 8'd4, 0);
        bus.op_valid = 1'b0;
        wait_idle();
        repeat (3) tick();
        check("t1_result_hold", 32'(bus.result), 32'd22);
        check("t1_busy_low", 32'(bus.busy), 32'd0);

        // len=3 back-to-back -> 44, result_valid after edge s+9
        start_job(8'd3, 16'd0, 16'd44, 1'b1);
        send_pair(8'd1, 8'd2, 0);
        send_pair(8'd3, 8'd4, 0);
        send_pair(8'd5, 8'd6, 0);
        bus.op_valid = 1'b0;
        wait_idle();
        check("t2_result_hold", 32'(bus.result), 32'd44);

        // len=2 with 4 idle cycles before each pair -> 17
        cnt0 = mac_en_cnt;
        start_job(8'd2, 16'd0, 16'd17, 1'b0);
        send_pair(8'd2, 8'd5, 4);
        send_pair(8'd7, 8'd1, 4);
        bus.op_valid = 1'b0;
        wait_idle();
        check("t3_mac_en_pulses", 32'(mac_en_cnt - cnt0), 32'd2);

        // len=0, bias=7 -> 7 in the cycle after the start edge
        cnt0 = mac_en_cnt;
        start_job(8'd0, 16'd7, 16'd7, 1'b1);
        wait_idle();
        check("t4_mac_en_pulses", 32'(mac_en_cnt - cnt0), 32'd0);
        check("t4_result_hold", 32'(bus.result), 32'd7);

        // (255,255) twice wraps to 64514; start pulsed while busy is ignored
        cnt0 = mac_en_cnt;
        start_job(8'd2, 16'd0, 16'd64514, 1'b1);
        send_pair(8'd255, 8'd255, 0);
        bus.start = 1'b1;
        bus.len   = 8'd1;
        bus.bias  = 16'd99;
        tick();
        bus.start = 1'b0;
        send_pair(8'd255, 8'd255, 0);
        bus.op_valid = 1'b0;
        wait_idle();
        repeat (4) tick();
        check("t5_mac_en_pulses", 32'(mac_en_cnt - cnt0), 32'd2);
        check("t5_result_hold", 32'(bus.result), 32'd64514);

        // Reset between the second issue edge and its capture
        start_job(8'd2, 16'd0, 16'd0, 1'b0);
        send_pair(8'd1, 8'd1, 0);
        send_pair(8'd2, 8'd2, 0);
        bus.op_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("midjob_reset");
        sb_q.delete();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_result_valid", 32'(bus.result_valid), 32'd0);
            check("post_reset_busy", 32'(bus.busy), 32'd0);
        end
        #1;
        start_job(8'd1, 16'd0, 16'd30, 1'b1);
        send_pair(8'd5, 8'd6, 0);
        bus.op_valid = 1'b0;
        wait_idle();
        check("t6_result_hold", 32'(bus.result), 32'd30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
